// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcode constants, fetch FSM states and the canonical NOP.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC select (Jalr > Jump > taken Branch > pc+4) with misalign detect.
module next_pc_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            branch,
    input  logic            jump,
    input  logic            jalr,
    input  logic            branch_cond,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        next_pc = pc + XLEN'(4);
        if (jalr) begin
            next_pc = (rs1_val + imm) & ~XLEN'(1);
        end else if (jump || (branch && branch_cond)) begin
            next_pc = pc + imm;
        end
        // bit 0 is cleared for JALR and never set by aligned flows, so only bit 1 signals a trap
        misaligned = next_pc[1];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer: requests one instruction at a time and holds it for decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            instr_ack,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            Jalr,
    input  logic            BranchCond,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic            misalign_trap
);

    fetch_state_t    state;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    next_pc_gen #(.XLEN(XLEN)) u_next_pc_gen (
        .pc          (pc),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .branch      (Branch),
        .jump        (Jump),
        .jalr        (Jalr),
        .branch_cond (BranchCond),
        .next_pc     (next_pc),
        .misaligned  (misaligned)
    );

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);

    // Outputs are registered alongside the state so they change exactly on transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            instr          <= NOP_INSTR;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            misalign_trap  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr       <= imem_rsp_data;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ack) begin
                        instr_valid <= 1'b0;
                        if (misaligned) begin
                            state         <= HALT;
                            misalign_trap <= 1'b1;
                        end else begin
                            pc             <= next_pc;
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                    instr_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule
